// File: rtl/xor_32bit_unit_pkg.sv
// ============================================================================
// Module : xor_32bit_unit_pkg
// Brief  : Shared ALU constants: datapath width and the XOR function code.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package xor_32bit_unit_pkg;

    localparam int WIDTH = 32;

    // MIPS R-type funct field for XOR; the ALU control decoder reuses it.
    localparam logic [5:0] ALU_FN_XOR = 6'b100110;

endpackage

`default_nettype wire

// File: rtl/xor_32bit_unit_xor_1bit.sv
// ============================================================================
// Module : xor_1bit
// Brief  : One-bit XOR built from four 2-input NANDs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xor_1bit (
    input  logic a,
    input  logic b,
    output logic y
);

    logic w_n_ab;
    logic w_n_a;
    logic w_n_b;

    // Classic four-NAND XOR: the shared NAND term gates both branches.
    assign w_n_ab = ~(a & b);
    assign w_n_a  = ~(a & w_n_ab);
    assign w_n_b  = ~(b & w_n_ab);
    assign y      = ~(w_n_a & w_n_b);

endmodule

`default_nettype wire

// File: rtl/xor_32bit_unit.sv
// ============================================================================
// Module : xor_32bit_unit
// Brief  : Registered 32-bit bitwise XOR slice with valid and zero flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xor_32bit_unit
    import xor_32bit_unit_pkg::*;
(
    output logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             out_valid,
    output logic             zero
);

    logic [WIDTH-1:0] w_x;
    logic [15:0]      w_or_l1;
    logic [7:0]       w_or_l2;
    logic [3:0]       w_or_l3;
    logic [1:0]       w_or_l4;
    logic             w_zero;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    genvar gi;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            xor_1bit u_xor (
                .a (a[gi]),
                .b (b[gi]),
                .y (w_x[gi])
            );
        end

        // Balanced OR tree; the final inversion makes it a 32-input NOR.
        for (gi = 0; gi < 16; gi++) begin : g_or_l1
            assign w_or_l1[gi] = w_x[2*gi] | w_x[2*gi+1];
        end
        for (gi = 0; gi < 8; gi++) begin : g_or_l2
            assign w_or_l2[gi] = w_or_l1[2*gi] | w_or_l1[2*gi+1];
        end
        for (gi = 0; gi < 4; gi++) begin : g_or_l3
            assign w_or_l3[gi] = w_or_l2[2*gi] | w_or_l2[2*gi+1];
        end
        for (gi = 0; gi < 2; gi++) begin : g_or_l4
            assign w_or_l4[gi] = w_or_l3[2*gi] | w_or_l3[2*gi+1];
        end
    endgenerate

    assign w_zero = ~(w_or_l4[0] | w_or_l4[1]);

    // Idle cycles hold result/zero so operand X never reaches the flops.
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            result_d    = w_x;
            zero_d      = w_zero;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_32bit_unit.sv
// ============================================================================
// Module : tb_xor_32bit_unit
// Brief  : Directed and random checks of the registered XOR slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_xor_32bit_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        out_valid;
    logic        zero;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference state: what the outputs should show after the last edge.
    logic [31:0] exp_result = '0;
    logic        exp_zero   = 1'b1;
    logic        exp_valid  = 1'b0;

    always #5 clk = ~clk;

    xor_32bit_unit dut (
        .result    (result),
        .a         (a),
        .b         (b),
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .out_valid (out_valid),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".result"}, result, exp_result);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, exp_zero});
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
    endtask

    // Drive one cycle, advance the model by the stated rules, then check.
    task automatic step(input logic rn, input logic v, input logic [31:0] av,
                        input logic [31:0] bv, input string tag);
        @(negedge clk);
        reset_n  = rn;
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_result = 32'h0;
            exp_zero   = 1'b1;
            exp_valid  = 1'b0;
        end else if (v) begin
            exp_result = av ^ bv;
            exp_zero   = ((av ^ bv) == 32'h0);
            exp_valid  = 1'b1;
        end else begin
            exp_valid  = 1'b0;
        end
        check_all(tag);
    endtask

    initial begin
        step(1'b0, 1'b0, 32'h0, 32'h0, "reset");
        step(1'b0, 1'b0, 32'h0, 32'h0, "reset2");

        step(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, "zero_zero");
        step(1'b1, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, "aa_aa");
        step(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, "aa_55");
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "ff_ff");
        step(1'b1, 1'b1, 32'h8000_0001, 32'h0000_0000, "msb_lsb");
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, "idle_hold");
        step(1'b1, 1'b0, 32'h0, 32'h0, "idle_hold2");

        // Capture on the reset edge must be discarded.
        step(1'b1, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, "pre_reset");
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, "reset_valid");
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "post_reset_idle");
        step(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000, "first_after_reset");

        // Single-bit lanes: each bit alone must clear zero.
        for (int i = 0; i < 32; i += 7) begin
            step(1'b1, 1'b1, 32'h1 << i, 32'h0, $sformatf("lane%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rv;
            logic        rr;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 15) != 0);
            step(rr, rv, ra, rb, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
